// File: rtl/arb4_rr.sv
// rtl/arb4_rr.sv - four-way round-robin arbiter with bounded hold time
//
// Purpose: grants one of four level-sensitive requesters at a time. The
// search order rotates from a pointer. An owner keeps the grant while it
// requests, but it is forced to rotate after HOLD_MAX consecutive cycles
// if another requester is waiting.
//
// Ports:
//   i_clk      in   1  clock, rising edge
//   i_rstn     in   1  asynchronous active-low reset
//   i_en       in   1  arbiter enable; low drops the grant
//   i_req      in   4  request per requester
//   o_gnt      out  4  one-hot grant, zero when o_gnt_vld is low
//   o_gnt_idx  out  2  current or last owner
//   o_gnt_vld  out  1  a grant is active
module arb4_rr #(
  parameter int HOLD_MAX = 8
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_en,
  input  logic [3:0] i_req,
  output logic [3:0] o_gnt,
  output logic [1:0] o_gnt_idx,
  output logic       o_gnt_vld
);

  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [7:0] cnt;

  logic [1:0] owner_p1;
  logic [2:0] win_ptr;   // {found, index} searched from ptr
  logic [2:0] win_nxt;   // {found, index} searched from owner+1
  logic       others;

  // The first set bit in the order base, base+1, base+2, base+3.
  // The loop runs backwards, so the earliest hit in that order is written last and wins.
  function automatic logic [2:0] pick(input logic [3:0] req, input logic [1:0] base);
    logic [1:0] cand;
    pick = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      cand = base + 2'(k);
      if (req[cand]) pick = {1'b1, cand};
    end
  endfunction

  function automatic logic [3:0] dec(input logic [1:0] idx);
    dec = 4'b0001 << idx;
  endfunction

  always_comb begin
    owner_p1 = o_gnt_idx + 2'd1;
    win_ptr  = pick(i_req, ptr);
    win_nxt  = pick(i_req, owner_p1);
    // o_gnt holds the owner's one-hot while BUSY, so this masks the owner out.
    others   = |(i_req & ~o_gnt);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      cnt       <= 8'd0;
      o_gnt     <= 4'b0000;
      o_gnt_idx <= 2'd0;
      o_gnt_vld <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_en && win_ptr[2]) begin
            state     <= BUSY;
            o_gnt_idx <= win_ptr[1:0];
            o_gnt     <= dec(win_ptr[1:0]);
            o_gnt_vld <= 1'b1;
            cnt       <= 8'd1;
          end
        end
        BUSY: begin
          if (!i_en) begin
            // The pointer and the index are kept, so arbitration resumes where it stopped.
            state     <= IDLE;
            o_gnt     <= 4'b0000;
            o_gnt_vld <= 1'b0;
            cnt       <= 8'd0;
          end else if (i_req[o_gnt_idx]) begin
            if (cnt == HOLD_LIM && others) begin
              // Forced rotation. The owner is last in the new order, so it cannot win again.
              ptr       <= owner_p1;
              o_gnt_idx <= win_nxt[1:0];
              o_gnt     <= dec(win_nxt[1:0]);
              cnt       <= 8'd1;
            end else if (cnt < HOLD_LIM) begin
              cnt <= cnt + 8'd1;
            end
          end else begin
            // Release. Hand over on the same edge if anyone else is asking.
            ptr <= owner_p1;
            if (win_nxt[2]) begin
              o_gnt_idx <= win_nxt[1:0];
              o_gnt     <= dec(win_nxt[1:0]);
              cnt       <= 8'd1;
            end else begin
              state     <= IDLE;
              o_gnt     <= 4'b0000;
              o_gnt_vld <= 1'b0;
              cnt       <= 8'd0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
